// File: rtl/alu16_pkg.sv
// Shared ALU definitions: FSM states, Booth digit encoding, default width.
package alu16_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Signed radix-4 Booth digit in {-2..+2}
    typedef logic signed [2:0] bdigit_t;

    localparam bdigit_t BD_ZERO = 3'sb000;
    localparam bdigit_t BD_P1   = 3'sb001;
    localparam bdigit_t BD_P2   = 3'sb010;
    localparam bdigit_t BD_M1   = 3'sb111;
    localparam bdigit_t BD_M2   = 3'sb110;

    // Map a Booth window {q[i+1], q[i], q[i-1]} to its signed digit
    function automatic bdigit_t booth_digit(input logic [2:0] q);
        bdigit_t d;
        case (q)
            3'b001, 3'b010: d = BD_P1;
            3'b011:         d = BD_P2;
            3'b100:         d = BD_M2;
            3'b101, 3'b110: d = BD_M1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit encoder: window bits -> sign / x1 / x2 selects.
// Zero digits (000/111) drive all selects low, so neg never inverts a zero.
module booth_r4_digit_enc
    import alu16_pkg::*;
(
    input  logic [2:0] q,
    output logic       neg,
    output logic       one,
    output logic       two
);

    bdigit_t w_d;

    // Decode the window once, derive the selects from the signed digit
    always_comb begin
        w_d = booth_digit(q);
        neg = (w_d == BD_M1) || (w_d == BD_M2);
        one = (w_d == BD_P1) || (w_d == BD_M1);
        two = (w_d == BD_P2) || (w_d == BD_M2);
    end

endmodule

// File: rtl/booth_radix4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one digit per clock on a single
// (WIDTH+2)-bit adder, start/busy/done handshake, result held until next done.
module booth_radix4_seq_mult
    import alu16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int ITER  = WIDTH / 2;
    localparam int AW    = WIDTH + 2;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("booth_radix4_seq_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_m;
    logic [AW-1:0]    r_a;
    logic [WIDTH:0]   r_q;      // LSB is the implicit q[-1]
    logic [CNT_W-1:0] r_cnt;

    logic             w_neg;
    logic             w_one;
    logic             w_two;
    logic [AW-1:0]    w_mext;
    logic [AW-1:0]    w_m2;
    logic [AW-1:0]    w_sel;
    logic [AW-1:0]    w_opnd;
    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_a_nx;
    logic [WIDTH:0]   w_q_nx;

    booth_r4_digit_enc u_enc (
        .q   (r_q[2:0]),
        .neg (w_neg),
        .one (w_one),
        .two (w_two)
    );

    assign w_mext = {{2{r_m[WIDTH-1]}}, r_m};
    assign w_m2   = {w_mext[AW-2:0], 1'b0};

    // Operand mux 0/M/2M, conditional invert; the +1 of negation is the carry-in
    always_comb begin
        w_sel = '0;
        if (w_one)      w_sel = w_mext;
        else if (w_two) w_sel = w_m2;
        w_opnd = w_neg ? ~w_sel : w_sel;
        w_sum  = r_a + w_opnd + AW'(w_neg);
    end

    // Arithmetic shift of {S,Q} right by two
    assign w_a_nx = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_q_nx = {w_sum[1:0], r_q[WIDTH:2]};

    // Control FSM plus datapath registers and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Operands are only looked at here, so X outside capture
                    // cannot reach the datapath
                    if (start) begin
                        r_m     <= op1;
                        r_a     <= '0;
                        r_q     <= {op2, 1'b0};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= w_a_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        result  <= {w_a_nx[WIDTH-1:0], w_q_nx[WIDTH:1]};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
